// File: rtl/maxpool2d_stream.sv
// rtl/maxpool2d_stream.sv - 2x2/stride-2 binary max-pool, frame in, one pooled row out per handshake.
// A captured frame is frozen in buf_q while its rows are streamed with a valid/ready handshake.
module maxpool2d_stream #(
  parameter int IMG_IN_SIZE  = 28,
  parameter int POOL         = 2,
  parameter int IMG_OUT_SIZE = IMG_IN_SIZE / POOL
) (
  input  logic                                    clk,
  input  logic                                    rstn,
  input  logic                                    img_in [0:IMG_IN_SIZE*IMG_IN_SIZE-1],
  input  logic                                    in_valid,
  output logic                                    in_ready,
  output logic                                    row_out [0:IMG_OUT_SIZE-1],
  output logic [((IMG_OUT_SIZE > 1) ? $clog2(IMG_OUT_SIZE) : 1)-1:0] row_idx,
  output logic                                    row_valid,
  input  logic                                    row_ready,
  output logic                                    frame_done
);

  localparam int IDX_W = (IMG_OUT_SIZE > 1) ? $clog2(IMG_OUT_SIZE) : 1;
  localparam int NPIX  = IMG_IN_SIZE * IMG_IN_SIZE;
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(IMG_OUT_SIZE - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t             state_q, state_d;
  logic               armed_q;
  logic [IDX_W-1:0]   row_q;
  logic               frame_done_q;
  logic               buf_q [0:NPIX-1];
  logic               pooled [0:IMG_OUT_SIZE-1][0:IMG_OUT_SIZE-1];
  logic               capture;
  logic               handshake;
  logic               last_row;

  // armed_q keeps in_ready low until the first edge after reset release
  assign capture   = (state_q == IDLE) && armed_q && in_valid;
  assign handshake = (state_q == SEND) && row_ready;
  assign last_row  = (row_q == LAST_ROW);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture) state_d = SEND;
      SEND:    if (handshake && last_row) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    row_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready = armed_q;
      SEND:    row_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      armed_q      <= 1'b0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < NPIX; i++) buf_q[i] <= 1'b0;
    end else begin
      armed_q      <= 1'b1;
      frame_done_q <= handshake && last_row;
      if (capture) begin
        row_q <= '0;
        for (int i = 0; i < NPIX; i++) buf_q[i] <= img_in[i];
      end else if (handshake && !last_row) begin
        row_q <= row_q + 1'b1;
      end
    end
  end

  // Odd trailing row/column are never addressed, so they cannot reach an output
  for (genvar gr = 0; gr < IMG_OUT_SIZE; gr++) begin : g_row
    for (genvar gc = 0; gc < IMG_OUT_SIZE; gc++) begin : g_col
      assign pooled[gr][gc] = buf_q[(POOL*gr)*IMG_IN_SIZE     + POOL*gc]
                            | buf_q[(POOL*gr)*IMG_IN_SIZE     + POOL*gc + 1]
                            | buf_q[(POOL*gr + 1)*IMG_IN_SIZE + POOL*gc]
                            | buf_q[(POOL*gr + 1)*IMG_IN_SIZE + POOL*gc + 1];
    end
  end

  always_comb begin
    for (int c = 0; c < IMG_OUT_SIZE; c++) row_out[c] = row_valid & pooled[row_q][c];
  end

  assign row_idx    = row_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool2d_stream.sv
// tb/tb_maxpool2d_stream.sv - directed + randomized bench for maxpool2d_stream (6x6 and 5x5 instances).
module tb_maxpool2d_stream;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic       img6 [0:35];
  logic       in_valid6, in_ready6, row_valid6, row_ready6, frame_done6;
  logic       row_out6 [0:2];
  logic [1:0] row_idx6;
  logic [2:0] out6;

  logic       img5 [0:24];
  logic       in_valid5, in_ready5, row_valid5, row_ready5, frame_done5;
  logic       row_out5 [0:1];
  logic [0:0] row_idx5;
  logic [1:0] out5;

  assign out6 = {row_out6[2], row_out6[1], row_out6[0]};
  assign out5 = {row_out5[1], row_out5[0]};

  maxpool2d_stream #(.IMG_IN_SIZE(6), .POOL(2), .IMG_OUT_SIZE(3)) dut6 (
    .clk(clk), .rstn(rstn), .img_in(img6), .in_valid(in_valid6), .in_ready(in_ready6),
    .row_out(row_out6), .row_idx(row_idx6), .row_valid(row_valid6), .row_ready(row_ready6),
    .frame_done(frame_done6));

  maxpool2d_stream #(.IMG_IN_SIZE(5), .POOL(2), .IMG_OUT_SIZE(2)) dut5 (
    .clk(clk), .rstn(rstn), .img_in(img5), .in_valid(in_valid5), .in_ready(in_ready5),
    .row_out(row_out5), .row_idx(row_idx5), .row_valid(row_valid5), .row_ready(row_ready5),
    .frame_done(frame_done5));

  int checks = 0;
  int errors = 0;
  int ref6 [0:35];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Max over each 2x2 block of the captured frame
  function automatic logic [2:0] model_row(input int r);
    logic [2:0] v;
    v = '0;
    for (int c = 0; c < 3; c++)
      for (int dr = 0; dr < 2; dr++)
        for (int dc = 0; dc < 2; dc++)
          if (ref6[(2*r+dr)*6 + 2*c+dc] != 0) v[c] = 1'b1;
    return v;
  endfunction

  // Starts at a negedge with dut6 ready; ends at the negedge of the frame_done cycle
  task automatic run_frame(input int stall0, input bit rand_stall, input bit noise);
    int stall;
    chk("in_ready_before_capture", in_ready6, 1);
    for (int i = 0; i < 36; i++) ref6[i] = int'(img6[i]);
    in_valid6 = 1'b1;
    @(negedge clk);
    in_valid6 = noise;
    if (noise) for (int i = 0; i < 36; i++) img6[i] = ~img6[i];
    for (int r = 0; r < 3; r++) begin
      stall = (r == 0) ? stall0 : (rand_stall ? int'($urandom_range(0, 2)) : 0);
      for (int s = 0; s <= stall; s++) begin
        chk("row_valid", row_valid6, 1);
        chk("row_idx", row_idx6, r);
        chk("row_out", out6, model_row(r));
        chk("in_ready_send", in_ready6, 0);
        chk("frame_done_send", frame_done6, 0);
        row_ready6 = (s == stall);
        @(negedge clk);
      end
    end
    row_ready6 = 1'b0;
    in_valid6  = 1'b0;
    chk("frame_done_pulse", frame_done6, 1);
    chk("in_ready_done", in_ready6, 1);
    chk("row_valid_done", row_valid6, 0);
    chk("row_out_idle", out6, 0);
  endtask

  task automatic rand_frame6();
    for (int i = 0; i < 36; i++) img6[i] = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    rstn = 1'b0;
    in_valid6 = 1'b1; row_ready6 = 1'b0; in_valid5 = 1'b0; row_ready5 = 1'b0;
    for (int i = 0; i < 36; i++) img6[i] = 1'b1;
    for (int i = 0; i < 25; i++) img5[i] = 1'b0;
    #1;
    chk("rst_in_ready", in_ready6, 0);
    chk("rst_row_valid", row_valid6, 0);
    chk("rst_row_idx", row_idx6, 0);
    chk("rst_row_out", out6, 0);
    chk("rst_frame_done", frame_done6, 0);
    repeat (2) @(negedge clk);
    chk("rst_ignores_in_valid", row_valid6, 0);
    rstn = 1'b1;
    in_valid6 = 1'b0;
    #1;
    chk("in_ready_before_first_edge", in_ready6, 0);
    @(negedge clk);
    chk("in_ready_after_release", in_ready6, 1);
    chk("idle_row_valid", row_valid6, 0);

    // all-zero frame, no backpressure
    for (int i = 0; i < 36; i++) img6[i] = 1'b0;
    run_frame(0, 0, 0);
    @(negedge clk);
    chk("frame_done_one_cycle", frame_done6, 0);

    // single pixel (3,4) -> only row 1 element 2
    for (int i = 0; i < 36; i++) img6[i] = 1'b0;
    img6[3*6+4] = 1'b1;
    run_frame(0, 0, 0);
    @(negedge clk);

    // all ones with 5 stalled cycles at row 0
    for (int i = 0; i < 36; i++) img6[i] = 1'b1;
    run_frame(5, 0, 0);
    @(negedge clk);

    // in_valid held during SEND with a different frame, then back-to-back capture
    rand_frame6();
    run_frame(1, 1, 1);
    rand_frame6();
    run_frame(0, 1, 0);
    @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      rand_frame6();
      run_frame(int'($urandom_range(0, 3)), 1, k[0]);
      if (k[1]) @(negedge clk);
    end
    @(negedge clk);

    // reset mid-frame while on row 1
    rand_frame6();
    for (int i = 0; i < 36; i++) ref6[i] = int'(img6[i]);
    in_valid6 = 1'b1;
    @(negedge clk);
    in_valid6 = 1'b0;
    chk("mid_row0_idx", row_idx6, 0);
    row_ready6 = 1'b1;
    @(negedge clk);
    row_ready6 = 1'b0;
    chk("mid_row1_idx", row_idx6, 1);
    chk("mid_row1_out", out6, model_row(1));
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_row_valid", row_valid6, 0);
    chk("mid_rst_row_out", out6, 0);
    chk("mid_rst_row_idx", row_idx6, 0);
    chk("mid_rst_in_ready", in_ready6, 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_frame_done", frame_done6, 0);
      chk("post_rst_in_ready", in_ready6, 1);
      chk("post_rst_row_valid", row_valid6, 0);
    end

    // 5x5: last row and column must be ignored
    for (int i = 0; i < 25; i++) img5[i] = ((i / 5) == 4) || ((i % 5) == 4);
    chk("in_ready5", in_ready5, 1);
    in_valid5 = 1'b1;
    @(negedge clk);
    in_valid5 = 1'b0;
    row_ready5 = 1'b1;
    chk("odd_row0_idx", row_idx5, 0);
    chk("odd_row0_out", out5, 2'b00);
    chk("odd_row0_valid", row_valid5, 1);
    @(negedge clk);
    chk("odd_row1_idx", row_idx5, 1);
    chk("odd_row1_out", out5, 2'b00);
    @(negedge clk);
    chk("odd_frame_done", frame_done5, 1);
    for (int i = 0; i < 25; i++) img5[i] = ~(((i / 5) == 4) || ((i % 5) == 4));
    in_valid5 = 1'b1;
    @(negedge clk);
    in_valid5 = 1'b0;
    chk("odd_inv_row0_out", out5, 2'b11);
    @(negedge clk);
    chk("odd_inv_row1_out", out5, 2'b11);
    @(negedge clk);
    chk("odd_inv_frame_done", frame_done5, 1);
    row_ready5 = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
